// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the two-requester UART register port arbiter.
// Included by the arbiter top and its round-robin picker.
package uart_arb_pkg;

  localparam int UART_DW    = 32;
  localparam int UART_AW    = 2;
  localparam int LOCK_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2,
    ST_HOLD  = 2'd3
  } arb_state_t;

  typedef logic mid_t;

endpackage

// File: rtl/uart_port_arbiter_picker.sv
// Two-way round-robin picker: names the winner among pending requests and,
// when told a grant was taken, moves its preference to the other requester.
module uart_rr_picker
  import uart_arb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output mid_t       o_winner
);

  mid_t r_ptr;

  // A lone request wins outright; the pointer only breaks ties.
  always_comb begin
    if (i_req == 2'b11) begin
      o_winner = r_ptr;
    end else if (i_req[1]) begin
      o_winner = 1'b1;
    end else begin
      o_winner = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= 1'b0;
    end else if (i_advance) begin
      r_ptr <= ~o_winner;
    end
  end

endmodule

// File: rtl/uart_port_arbiter.sv
// Shares one UART register port between M0 (CPU) and M1 (debug/boot) with
// round-robin arbitration and an optional ownership lock with idle timeout.
//
// Handshake: a requester raises REQ with stable command fields and holds them
// until its one-cycle ACK; the UART side sees exactly one WE/RE strobe cycle
// (ISSUE) per transaction, and ACK follows in the next cycle (DONE).
module uart_port_arbiter
  import uart_arb_pkg::*;
#(
  parameter int DW       = UART_DW,
  parameter int AW       = UART_AW,
  parameter int LOCK_MAX = 255
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          M0_REQ,
  input  logic          M1_REQ,
  input  logic          M0_LOCK,
  input  logic          M1_LOCK,
  input  logic          M0_WE,
  input  logic          M1_WE,
  input  logic          M0_RE,
  input  logic          M1_RE,
  input  logic [AW-1:0] M0_A,
  input  logic [AW-1:0] M1_A,
  input  logic [DW-1:0] M0_WD,
  input  logic [DW-1:0] M1_WD,
  output logic          M0_ACK,
  output logic          M1_ACK,
  output logic [DW-1:0] M0_RD,
  output logic [DW-1:0] M1_RD,
  output logic          U_WE,
  output logic          U_RE,
  output logic [AW-1:0] U_A,
  output logic [DW-1:0] U_WD,
  input  logic [DW-1:0] U_RD,
  output logic          OWNER,
  output logic          LOCKED,
  output arb_state_t    DBG_STATE
);

  localparam logic [LOCK_CNT_W-1:0] LOCK_LIMIT = LOCK_CNT_W'(LOCK_MAX);

  arb_state_t            r_state;
  mid_t                  r_owner;
  logic                  r_locked;
  logic [LOCK_CNT_W-1:0] r_cnt;
  logic [DW-1:0]         r_rd0;
  logic [DW-1:0]         r_rd1;

  logic [1:0]            w_req;
  logic                  w_grant;
  mid_t                  w_winner;
  logic                  w_issue;
  logic                  w_own_req;
  logic                  w_own_lock;
  logic                  w_own_we;
  logic                  w_own_re;
  logic [AW-1:0]         w_own_a;
  logic [DW-1:0]         w_own_wd;
  logic [LOCK_CNT_W-1:0] w_cnt_inc;

  assign w_req     = {M1_REQ, M0_REQ};
  assign w_grant   = (r_state == ST_IDLE) && (|w_req);
  assign w_issue   = (r_state == ST_ISSUE);
  assign w_cnt_inc = r_cnt + 1'b1;

  uart_rr_picker u_picker (
    .i_clk     (CLK),
    .i_rst     (RESET),
    .i_req     (w_req),
    .i_advance (w_grant),
    .o_winner  (w_winner)
  );

  assign w_own_req  = r_owner ? M1_REQ  : M0_REQ;
  assign w_own_lock = r_owner ? M1_LOCK : M0_LOCK;
  assign w_own_we   = r_owner ? M1_WE   : M0_WE;
  assign w_own_re   = r_owner ? M1_RE   : M0_RE;
  assign w_own_a    = r_owner ? M1_A    : M0_A;
  assign w_own_wd   = r_owner ? M1_WD   : M0_WD;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state  <= ST_IDLE;
      r_owner  <= 1'b0;
      r_locked <= 1'b0;
      r_cnt    <= '0;
      r_rd0    <= '0;
      r_rd1    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_owner <= w_winner;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Read data is combinational from U_A, so it is valid this cycle.
          if (r_owner) begin
            r_rd1 <= U_RD;
          end else begin
            r_rd0 <= U_RD;
          end
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (w_own_lock) begin
            r_state  <= ST_HOLD;
            r_locked <= 1'b1;
            r_cnt    <= '0;
          end else begin
            r_state  <= ST_IDLE;
            r_locked <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (w_own_req) begin
            r_state <= ST_ISSUE;
          end else if (!w_own_lock || (w_cnt_inc == LOCK_LIMIT)) begin
            r_state  <= ST_IDLE;
            r_locked <= 1'b0;
            r_cnt    <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Port drive is decoded from registered state so reset drops it at once.
  assign U_WE = w_issue & w_own_we;
  assign U_RE = w_issue & w_own_re & ~w_own_we;
  assign U_A  = w_issue ? w_own_a  : '0;
  assign U_WD = w_issue ? w_own_wd : '0;

  assign M0_ACK    = (r_state == ST_DONE) && !r_owner;
  assign M1_ACK    = (r_state == ST_DONE) &&  r_owner;
  assign M0_RD     = r_rd0;
  assign M1_RD     = r_rd1;
  assign OWNER     = r_owner;
  assign LOCKED    = r_locked;
  assign DBG_STATE = r_state;

endmodule

// File: tb/tb_uart_port_arbiter.sv
// Bench for uart_port_arbiter: directed scenarios plus random two-requester
// traffic checked against per-requester expected queues and a UART memory model.
module tb_uart_port_arbiter;
  import uart_arb_pkg::*;

  localparam int DW       = 32;
  localparam int AW       = 2;
  localparam int LOCK_MAX = 4;
  localparam int CW       = 2 + AW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [1:0]    req, lock, we, re;
  logic [AW-1:0] a_v  [2];
  logic [DW-1:0] wd_v [2];
  logic          m0_ack, m1_ack;
  logic [DW-1:0] m0_rd, m1_rd;
  logic          u_we, u_re;
  logic [AW-1:0] u_a;
  logic [DW-1:0] u_wd, u_rd;
  logic          owner, locked;
  arb_state_t    dbg_state;

  logic [1:0]    ack_v;
  logic [DW-1:0] rd_v [2];
  assign ack_v   = {m1_ack, m0_ack};
  assign rd_v[0] = m0_rd;
  assign rd_v[1] = m1_rd;

  uart_port_arbiter #(.DW(DW), .AW(AW), .LOCK_MAX(LOCK_MAX)) dut (
    .CLK(clk), .RESET(rst),
    .M0_REQ(req[0]), .M1_REQ(req[1]),
    .M0_LOCK(lock[0]), .M1_LOCK(lock[1]),
    .M0_WE(we[0]), .M1_WE(we[1]),
    .M0_RE(re[0]), .M1_RE(re[1]),
    .M0_A(a_v[0]), .M1_A(a_v[1]),
    .M0_WD(wd_v[0]), .M1_WD(wd_v[1]),
    .M0_ACK(m0_ack), .M1_ACK(m1_ack),
    .M0_RD(m0_rd), .M1_RD(m1_rd),
    .U_WE(u_we), .U_RE(u_re), .U_A(u_a), .U_WD(u_wd), .U_RD(u_rd),
    .OWNER(owner), .LOCKED(locked), .DBG_STATE(dbg_state)
  );

  // ---------------- UART register block emulation ----------------
  logic [DW-1:0] uart_mem [4];
  logic          pre_we;
  logic [AW-1:0] pre_a;
  logic [DW-1:0] pre_d;
  assign u_rd = uart_mem[u_a];
  always @(posedge clk) begin
    if (pre_we) uart_mem[pre_a] <= pre_d;
    else if (u_we) uart_mem[u_a] <= u_wd;
  end

  // ---------------- scoreboard state ----------------
  logic [CW-1:0] exp_q0[$];
  logic [CW-1:0] exp_q1[$];
  logic [DW-1:0] ref_mem [4];
  logic [DW-1:0] last_rd [2];
  int            ack_log[$];
  logic          prev_we, prev_re;
  logic [AW-1:0] prev_a;
  logic [DW-1:0] prev_wd;
  int            n_vec  = 0;
  int            n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_txn(input int m, input logic t_we, input logic t_re,
                        input logic [AW-1:0] t_a, input logic [DW-1:0] t_wd,
                        input logic t_lock);
    int cyc;
    @(posedge clk); #1;
    if (m == 0) exp_q0.push_back({t_we, t_re, t_a, t_wd});
    else        exp_q1.push_back({t_we, t_re, t_a, t_wd});
    we[m] = t_we; re[m] = t_re; a_v[m] = t_a; wd_v[m] = t_wd;
    lock[m] = t_lock; req[m] = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!ack_v[m] && cyc < 1000);
    chk($sformatf("ack_seen_m%0d", m), 64'(ack_v[m]), 64'd1);
  endtask

  task automatic release_req(input int m, input logic t_lock);
    @(posedge clk); #1;
    req[m]  = 1'b0;
    lock[m] = t_lock;
  endtask

  task automatic preload(input logic [AW-1:0] p_a, input logic [DW-1:0] p_d);
    @(posedge clk); #1;
    pre_we = 1'b1; pre_a = p_a; pre_d = p_d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic rand_driver(input int m, input int n);
    for (int i = 0; i < n; i++) begin
      logic [1:0] cmd;
      logic       lk;
      int         gap;
      cmd = 2'($urandom_range(0, 3));
      lk  = ($urandom_range(0, 3) == 0);
      gap = $urandom_range(0, 3);
      do_txn(m, cmd[1], cmd[0], 2'($urandom_range(0, 3)), $urandom, lk);
      if (gap != 0) begin
        release_req(m, lk);
        repeat (gap - 1) @(posedge clk);
      end
    end
    release_req(m, 1'b0);
  endtask

  // ---------------- monitor ----------------
  task automatic check_ack(input int m);
    logic [CW-1:0] e;
    logic          e_we, e_re;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_wd, e_rd;
    if ((m == 0 && exp_q0.size() == 0) || (m == 1 && exp_q1.size() == 0)) begin
      chk($sformatf("unexpected_ack_m%0d", m), 64'(ack_v[m]), 64'd0);
      return;
    end
    e = (m == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
    {e_we, e_re, e_a, e_wd} = e;
    e_rd = ref_mem[e_a];
    chk($sformatf("strobe_we_m%0d", m), 64'(prev_we), 64'(e_we));
    chk($sformatf("strobe_re_m%0d", m), 64'(prev_re), 64'(e_re & ~e_we));
    chk($sformatf("issue_addr_m%0d", m), 64'(prev_a), 64'(e_a));
    chk($sformatf("issue_wd_m%0d", m), 64'(prev_wd), 64'(e_wd));
    chk($sformatf("rd_m%0d", m), 64'(rd_v[m]), 64'(e_rd));
    chk($sformatf("owner_m%0d", m), 64'(owner), 64'(m));
    chk($sformatf("port_quiet_m%0d", m), 64'({u_we, u_re, u_a, u_wd}), 64'd0);
    if (e_we) ref_mem[e_a] = e_wd;
    last_rd[m] = e_rd;
    ack_log.push_back(m);
  endtask

  initial begin
    prev_we = 1'b0; prev_re = 1'b0; prev_a = '0; prev_wd = '0;
    last_rd[0] = '0; last_rd[1] = '0;
    forever begin
      @(negedge clk);
      if (pre_we) ref_mem[pre_a] = pre_d;
      if (rst) begin
        last_rd[0] = '0; last_rd[1] = '0;
        prev_we = 1'b0; prev_re = 1'b0;
      end else begin
        chk("single_ack", 64'(m0_ack & m1_ack), 64'd0);
        for (int m = 0; m < 2; m++) begin
          if (ack_v[m]) check_ack(m);
          else chk($sformatf("rd_hold_m%0d", m), 64'(rd_v[m]), 64'(last_rd[m]));
        end
        if ((prev_we | prev_re) && !(m0_ack | m1_ack))
          chk("ack_after_strobe", 64'(m0_ack | m1_ack), 64'd1);
        prev_we = u_we; prev_re = u_re; prev_a = u_a; prev_wd = u_wd;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus and directed checks ----------------
  int exp_order [4];

  initial begin
    rst = 1'b1; req = '0; lock = '0; we = '0; re = '0;
    a_v[0] = '0; a_v[1] = '0; wd_v[0] = '0; wd_v[1] = '0;
    pre_we = 1'b0; pre_a = '0; pre_d = '0;
    for (int i = 0; i < 4; i++) preload(2'(i), $urandom);

    @(negedge clk);
    chk("rst_u_we", 64'(u_we), 64'd0);
    chk("rst_u_re", 64'(u_re), 64'd0);
    chk("rst_u_a", 64'(u_a), 64'd0);
    chk("rst_u_wd", 64'(u_wd), 64'd0);
    chk("rst_acks", 64'(ack_v), 64'd0);
    chk("rst_m0_rd", 64'(m0_rd), 64'd0);
    chk("rst_m1_rd", 64'(m1_rd), 64'd0);
    chk("rst_owner", 64'(owner), 64'd0);
    chk("rst_locked", 64'(locked), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    #2 rst = 1'b0;

    // Both requesters held continuously: strict alternation starting at M0.
    ack_log.delete();
    fork
      begin
        do_txn(0, 1'b1, 1'b0, 2'd1, $urandom, 1'b0);
        do_txn(0, 1'b0, 1'b1, 2'd3, $urandom, 1'b0);
        release_req(0, 1'b0);
      end
      begin
        do_txn(1, 1'b0, 1'b1, 2'd1, $urandom, 1'b0);
        do_txn(1, 1'b1, 1'b0, 2'd2, $urandom, 1'b0);
        release_req(1, 1'b0);
      end
    join
    exp_order = '{0, 1, 0, 1};
    chk("rr_log_size", 64'(ack_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < ack_log.size(); i++)
      chk($sformatf("rr_order_%0d", i), 64'(ack_log[i]), 64'(exp_order[i]));

    // M0 alone writes 0x41 to address 0: latency and strobe width.
    fork
      do_txn(0, 1'b1, 1'b0, 2'd0, 32'h41, 1'b0);
      begin
        @(posedge clk); #1;
        @(negedge clk);
        chk("w_idle_we", 64'(u_we), 64'd0);
        @(negedge clk);
        chk("w_issue_we", 64'(u_we), 64'd1);
        chk("w_issue_a", 64'(u_a), 64'd0);
        chk("w_issue_wd", 64'(u_wd), 64'h41);
        chk("w_issue_noack", 64'(m0_ack), 64'd0);
        @(negedge clk);
        chk("w_done_ack", 64'(m0_ack), 64'd1);
        chk("w_done_we", 64'(u_we), 64'd0);
        chk("w_done_m1_ack", 64'(m1_ack), 64'd0);
      end
    join
    release_req(0, 1'b0);

    // M1 reads address 2 holding 0x155; result must survive an M0 write.
    preload(2'd2, 32'h0000_0155);
    fork
      do_txn(1, 1'b0, 1'b1, 2'd2, $urandom, 1'b0);
      begin
        @(posedge clk); #1;
        @(negedge clk);
        chk("r_idle_re", 64'(u_re), 64'd0);
        @(negedge clk);
        chk("r_issue_re", 64'(u_re), 64'd1);
        chk("r_issue_we", 64'(u_we), 64'd0);
        chk("r_issue_a", 64'(u_a), 64'd2);
        @(negedge clk);
        chk("r_done_ack", 64'(m1_ack), 64'd1);
        chk("r_done_rd", 64'(m1_rd), 64'h155);
        chk("r_done_re", 64'(u_re), 64'd0);
      end
    join
    release_req(1, 1'b0);
    do_txn(0, 1'b1, 1'b0, 2'd2, 32'h0000_AAAA, 1'b0);
    release_req(0, 1'b0);
    repeat (2) @(negedge clk);
    chk("r_rd_held", 64'(m1_rd), 64'h155);

    // M0 locked for three back-to-back transactions while M1 waits.
    ack_log.delete();
    fork
      begin
        do_txn(0, 1'b0, 1'b1, 2'd2, $urandom, 1'b1);
        do_txn(0, 1'b1, 1'b0, 2'd3, $urandom, 1'b1);
        chk("lock_held_2", 64'(locked), 64'd1);
        do_txn(0, 1'b0, 1'b1, 2'd3, $urandom, 1'b1);
        chk("lock_held_3", 64'(locked), 64'd1);
        release_req(0, 1'b0);
      end
      begin
        @(posedge clk);
        do_txn(1, 1'b0, 1'b1, 2'd0, $urandom, 1'b0);
        release_req(1, 1'b0);
      end
    join
    exp_order = '{0, 0, 0, 1};
    chk("lock_log_size", 64'(ack_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < ack_log.size(); i++)
      chk($sformatf("lock_order_%0d", i), 64'(ack_log[i]), 64'(exp_order[i]));
    chk("lock_released", 64'(locked), 64'd0);

    // Lock timeout: M0 keeps LOCK but stops requesting; M1 is waiting.
    fork
      begin
        do_txn(0, 1'b0, 1'b1, 2'd1, $urandom, 1'b1);
        release_req(0, 1'b1);
      end
      begin
        @(posedge clk);
        do_txn(1, 1'b1, 1'b0, 2'd3, $urandom, 1'b0);
        release_req(1, 1'b0);
      end
      begin
        int k;
        k = 0;
        while (!m0_ack && k < 50) begin
          @(negedge clk);
          k++;
        end
        chk("to_m0_ack", 64'(m0_ack), 64'd1);
        for (int j = 1; j <= 20; j++) begin
          @(negedge clk);
          if (j <= LOCK_MAX) chk("to_locked_hold", 64'(locked), 64'd1);
          if (j == LOCK_MAX + 1) chk("to_forced_release", 64'(locked), 64'd0);
          if (m1_ack) begin
            chk("to_m1_ack_cycle", 64'(j), 64'(LOCK_MAX + 3));
            break;
          end
          if (j == 20) chk("to_m1_ack_seen", 64'(m1_ack), 64'd1);
        end
      end
    join
    release_req(0, 1'b0);

    // Reset during ISSUE of an M0 write: strobe drops at once, no ACK.
    @(posedge clk); #1;
    we[0] = 1'b1; re[0] = 1'b0; a_v[0] = 2'd1; wd_v[0] = 32'hDEAD_BEEF; req[0] = 1'b1;
    @(negedge clk);
    chk("rst_mid_idle_we", 64'(u_we), 64'd0);
    @(negedge clk);
    chk("rst_mid_issue_we", 64'(u_we), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_we_async", 64'(u_we), 64'd0);
    chk("rst_mid_wd_async", 64'(u_wd), 64'd0);
    chk("rst_mid_no_ack", 64'(m0_ack), 64'd0);
    req[0] = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    chk("rst_mid_m0_rd", 64'(m0_rd), 64'd0);
    chk("rst_mid_m1_rd", 64'(m1_rd), 64'd0);
    chk("rst_mid_owner", 64'(owner), 64'd0);
    repeat (4) begin
      @(negedge clk);
      chk("rst_mid_no_late_ack", 64'(m0_ack), 64'd0);
    end
    ack_log.delete();
    fork
      begin
        do_txn(0, 1'b1, 1'b0, 2'd1, 32'hDEAD_BEEF, 1'b0);
        release_req(0, 1'b0);
      end
      begin
        do_txn(1, 1'b0, 1'b1, 2'd1, $urandom, 1'b0);
        release_req(1, 1'b0);
      end
    join
    chk("rst_re_log_size", 64'(ack_log.size()), 64'd2);
    if (ack_log.size() == 2) begin
      chk("rst_re_first", 64'(ack_log[0]), 64'd0);
      chk("rst_re_second", 64'(ack_log[1]), 64'd1);
    end

    // Random concurrent traffic with occasional locks.
    fork
      rand_driver(0, 40);
      rand_driver(1, 40);
    join

    repeat (10) @(negedge clk);
    chk("q0_drained", 64'(exp_q0.size()), 64'd0);
    chk("q1_drained", 64'(exp_q1.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
